// File: rtl/cpr_pkg.sv
// Shared types and constants for the CPR (Amstrad Plus cartridge) chunk loader.
package cpr_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StCkId,
        StCkSize,
        StData,
        StSkip,
        StPadChk,
        StFill,
        StDone,
        StError
    } cpr_state_e;

    // FourCCs are stored first-byte-in-MSB, matching file order.
    localparam logic [31:0] FCC_RIFF = 32'h5249_4646;
    localparam logic [31:0] FCC_AMS  = 32'h414D_5321;
    localparam logic [15:0] FCC_CB   = 16'h6362;

    localparam int unsigned CHUNK_BYTES = 16384;
    localparam int unsigned MAX_CHUNKS  = 32;

    function automatic logic [7:0] fcc_byte(input logic [31:0] fcc, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = fcc[31:24];
            2'd1:    b = fcc[23:16];
            2'd2:    b = fcc[15:8];
            default: b = fcc[7:0];
        endcase
        return b;
    endfunction

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

endpackage

// File: rtl/cpr_write_port.sv
// Single-entry SDRAM write request register and the ioctl_wait backpressure it implies.
module cpr_write_port (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        issue,
    input  logic [22:0] issue_addr,
    input  logic [7:0]  issue_data,
    input  logic        hold_wait,
    input  logic        cart_ack,
    output logic        cart_wr,
    output logic [22:0] cart_addr,
    output logic [7:0]  cart_data,
    output logic        ioctl_wait
);

    logic        wr_q, wr_d;
    logic [22:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    always_ff @(posedge clk_48) begin
        if (reset) begin
            wr_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // The parser never issues while a request is pending, so issue and ack cannot collide.
    always_comb begin
        wr_d   = wr_q;
        addr_d = addr_q;
        data_d = data_q;
        if (issue) begin
            wr_d   = 1'b1;
            addr_d = issue_addr;
            data_d = issue_data;
        end else if (wr_q && cart_ack) begin
            wr_d = 1'b0;
        end
    end

    assign cart_wr    = wr_q;
    assign cart_addr  = addr_q;
    assign cart_data  = data_q;
    assign ioctl_wait = wr_q || hold_wait;

endmodule

// File: rtl/cpr_chunk_loader.sv
// Streaming CPR/RIFF cartridge image parser writing cbNN chunks into SDRAM.
// Optional build macro CPR_PAD_FILL_EN pads short chunks with 8'hFF up to a full 16K bank.
module cpr_chunk_loader
    import cpr_pkg::*;
#(
    parameter logic [7:0]  CPR_INDEX = 8'd5,
    parameter logic [22:0] CART_BASE = 23'h000000
) (
    input  logic        clk_48,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic [7:0]  ioctl_index,
    output logic        ioctl_wait,
    output logic [22:0] cart_addr,
    output logic [7:0]  cart_data,
    output logic        cart_wr,
    input  logic        cart_ack,
    output logic        cpr_valid,
    output logic        cpr_error,
    output logic [5:0]  chunk_count
);

    cpr_state_e  state_q, state_d;
    logic        active_q, active_d;
    logic        end_q, end_d;
    logic [24:0] pos_q, pos_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [23:0] id_q, id_d;
    logic [31:0] size_q, size_d;
    logic [31:0] rem_q, rem_d;
    logic [13:0] off_q, off_d;
    logic [4:0]  chunk_q, chunk_d;
    logic        is_cart_q, is_cart_d;
    logic [5:0]  count_q, count_d;

    logic        active, start, fall, end_req, end_eval;
    logic        parsing, byte_in, addr_ok, chunk_done;
    logic [6:0]  cb_num;
    logic [5:0]  count_inc;
    logic        issue, hold_wait;
    logic [22:0] issue_addr;
    logic [7:0]  issue_data;

    assign active   = ioctl_download && (ioctl_index == CPR_INDEX);
    assign start    = active && !active_q;
    assign fall     = !active && active_q;
    assign end_req  = fall || end_q;
    // End-of-download is judged only once the last write has drained.
    assign end_eval = end_req && !cart_wr && (state_q != StFill);

    assign parsing = (state_q == StHdr) || (state_q == StCkId) || (state_q == StCkSize) ||
                     (state_q == StData) || (state_q == StSkip) || (state_q == StPadChk);
    assign byte_in = active && ioctl_wr && !ioctl_wait && parsing;
    assign addr_ok = (ioctl_addr == pos_q);

    // Low nibble of an ASCII digit is its value; only meaningful once both are digits.
    assign cb_num    = 7'(id_q[3:0]) * 7'd10 + 7'(ioctl_dout[3:0]);
    assign count_inc = (count_q >= 6'(MAX_CHUNKS)) ? count_q : count_q + 6'd1;

    always_ff @(posedge clk_48) begin
        if (reset) begin
            state_q   <= StIdle;
            active_q  <= 1'b0;
            end_q     <= 1'b0;
            pos_q     <= '0;
            cnt_q     <= '0;
            id_q      <= '0;
            size_q    <= '0;
            rem_q     <= '0;
            off_q     <= '0;
            chunk_q   <= '0;
            is_cart_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            end_q     <= end_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            id_q      <= id_d;
            size_q    <= size_d;
            rem_q     <= rem_d;
            off_q     <= off_d;
            chunk_q   <= chunk_d;
            is_cart_q <= is_cart_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        active_d   = active;
        end_d      = end_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        size_d     = size_q;
        rem_d      = rem_q;
        off_d      = off_q;
        chunk_d    = chunk_q;
        is_cart_d  = is_cart_q;
        count_d    = count_q;
        chunk_done = 1'b0;

        if (start) begin
            state_d = StHdr;
            end_d   = 1'b0;
            pos_d   = '0;
            cnt_d   = '0;
            count_d = '0;
        end else if (end_eval) begin
            end_d = 1'b0;
            if (state_q == StCkId && cnt_q == 4'd0 && count_q != 6'd0) begin
                state_d = StDone;
            end else if (state_q != StError && state_q != StDone) begin
                state_d = StError;
            end
        end else begin
            end_d = end_req;
            if (byte_in && !addr_ok) begin
                state_d = StError;
            end else if (byte_in) begin
                pos_d = pos_q + 25'd1;
                case (state_q)
                    StHdr: begin
                        cnt_d = cnt_q + 4'd1;
                        if ((cnt_q < 4'd4 && ioctl_dout != fcc_byte(FCC_RIFF, cnt_q[1:0])) ||
                            (cnt_q >= 4'd8 && ioctl_dout != fcc_byte(FCC_AMS, cnt_q[1:0]))) begin
                            state_d = StError;
                        end else if (cnt_q == 4'd11) begin
                            state_d = StCkId;
                            cnt_d   = '0;
                        end
                    end
                    StCkId: begin
                        id_d  = {id_q[15:0], ioctl_dout};
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd3) begin
                            cnt_d     = '0;
                            state_d   = StCkSize;
                            is_cart_d = 1'b0;
                            if (id_q[23:8] == FCC_CB) begin
                                if (is_digit(id_q[7:0]) && is_digit(ioctl_dout) &&
                                    cb_num < 7'(MAX_CHUNKS)) begin
                                    is_cart_d = 1'b1;
                                    chunk_d   = cb_num[4:0];
                                end else begin
                                    state_d = StError;
                                end
                            end
                        end
                    end
                    StCkSize: begin
                        size_d = {ioctl_dout, size_q[31:8]};
                        cnt_d  = cnt_q + 4'd1;
                        if (cnt_q == 4'd3) begin
                            cnt_d = '0;
                            rem_d = size_d;
                            off_d = '0;
                            if (is_cart_q) begin
                                if (size_d > CHUNK_BYTES) begin
                                    state_d = StError;
                                end else if (size_d == 32'd0) begin
                                    chunk_done = 1'b1;
                                end else begin
                                    state_d = StData;
                                end
                            end else begin
                                state_d = (size_d == 32'd0) ? StCkId : StSkip;
                            end
                        end
                    end
                    StData: begin
                        off_d = off_q + 14'd1;
                        rem_d = rem_q - 32'd1;
                        if (rem_q == 32'd1) begin
                            chunk_done = 1'b1;
                        end
                    end
                    StSkip: begin
                        rem_d = rem_q - 32'd1;
                        if (rem_q == 32'd1) begin
                            state_d = size_q[0] ? StPadChk : StCkId;
                            cnt_d   = '0;
                        end
                    end
                    StPadChk: begin
                        state_d = StCkId;
                        cnt_d   = '0;
                    end
                    default: ;
                endcase

                if (chunk_done) begin
                    cnt_d   = '0;
                    state_d = size_d[0] ? StPadChk : StCkId;
                    count_d = count_inc;
`ifdef CPR_PAD_FILL_EN
                    // A short chunk only counts once the rest of its bank has been padded.
                    if (!size_d[14]) begin
                        state_d = StFill;
                        count_d = count_q;
                    end
`endif
                end
            end

`ifdef CPR_PAD_FILL_EN
            if (state_q == StFill && !cart_wr) begin
                off_d = off_q + 14'd1;
                if (off_q == 14'(CHUNK_BYTES - 1)) begin
                    count_d = count_inc;
                    cnt_d   = '0;
                    state_d = size_q[0] ? StPadChk : StCkId;
                end
            end
`endif
        end
    end

    always_comb begin
        issue      = 1'b0;
        issue_data = ioctl_dout;
        hold_wait  = 1'b0;
        if (state_q == StData && byte_in && addr_ok) begin
            issue = 1'b1;
        end
`ifdef CPR_PAD_FILL_EN
        if (state_q == StFill) begin
            hold_wait  = 1'b1;
            issue      = !cart_wr;
            issue_data = 8'hFF;
        end
`endif
    end

    assign issue_addr  = {CART_BASE[22:19], chunk_q, off_q};
    assign cpr_valid   = (state_q == StDone);
    assign cpr_error   = (state_q == StError);
    assign chunk_count = count_q;

    cpr_write_port u_write_port (
        .clk_48     (clk_48),
        .reset      (reset),
        .issue      (issue),
        .issue_addr (issue_addr),
        .issue_data (issue_data),
        .hold_wait  (hold_wait),
        .cart_ack   (cart_ack),
        .cart_wr    (cart_wr),
        .cart_addr  (cart_addr),
        .cart_data  (cart_data),
        .ioctl_wait (ioctl_wait)
    );

endmodule
